// File: rtl/alu_multiciclo_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and op-class helpers.
// Used by alu_multiciclo (optional single-cycle multiplier: ALU_MUL_1CYCLE_EN).
package alu_multiciclo_pkg;

  localparam logic [4:0] OPAND    = 5'd0;
  localparam logic [4:0] OPOR     = 5'd1;
  localparam logic [4:0] OPXOR    = 5'd2;
  localparam logic [4:0] OPADD    = 5'd3;
  localparam logic [4:0] OPSUB    = 5'd4;
  localparam logic [4:0] OPSLT    = 5'd5;
  localparam logic [4:0] OPSLTU   = 5'd6;
  localparam logic [4:0] OPGE     = 5'd7;
  localparam logic [4:0] OPGEU    = 5'd8;
  localparam logic [4:0] OPSLL    = 5'd9;
  localparam logic [4:0] OPSRL    = 5'd10;
  localparam logic [4:0] OPSRA    = 5'd11;
  localparam logic [4:0] OPLUI    = 5'd12;
  localparam logic [4:0] OPBEQ    = 5'd13;
  localparam logic [4:0] OPBNE    = 5'd14;
  localparam logic [4:0] OPMUL    = 5'd15;
  localparam logic [4:0] OPMULH   = 5'd16;
  localparam logic [4:0] OPMULHSU = 5'd17;
  localparam logic [4:0] OPMULHU  = 5'd18;
  localparam logic [4:0] OPDIV    = 5'd19;
  localparam logic [4:0] OPDIVU   = 5'd20;
  localparam logic [4:0] OPREM    = 5'd21;
  localparam logic [4:0] OPREMU   = 5'd22;

  localparam logic [31:0] ZERO = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OPMUL) && (op <= OPREMU);
  endfunction

endpackage

// File: rtl/alu_multiciclo_divisor.sv
// Restoring radix-2 divider on magnitudes; its step counter is also the ALU's
// iteration counter. quotient/remainder show the step result, final when last=1.
module alu_divisor_iterativo #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            active_q;
  logic [CNTW-1:0] cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, den_q;
  logic [XLEN:0]   shifted;
  logic            fits;

  // Partial remainder never reaches 2*divisor, so XLEN+1 bits hold the shifted value
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign fits      = shifted >= {1'b0, den_q};
  assign remainder = fits ? (shifted[XLEN-1:0] - den_q) : shifted[XLEN-1:0];
  assign quotient  = {quo_q[XLEN-2:0], fits};
  assign last      = active_q && (cnt_q == CNTW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      quo_q    <= dividend;
      rem_q    <= '0;
      den_q    <= divisor;
    end else if (active_q) begin
      quo_q <= quotient;
      rem_q <= remainder;
      cnt_q <= cnt_q + CNTW'(1);
      if (kill || last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle RV32IM ALU: single-cycle logic/shift/compare, iterative MUL/DIV.
// Define ALU_MUL_1CYCLE_EN to use a combinational multiplier instead.
module alu_multiciclo
  import alu_multiciclo_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(XLEN) + 1
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iStart,
  input  logic            iKill,
  input  logic [4:0]      iControlSignal,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oReady,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult,
  output logic            oZero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_n;
  logic            accept, a_neg, b_neg, b_zero, div_ovf, is_div, div_iter, iter_mul;
  logic            div_start, div_last, load_res;
  logic [XLEN-1:0] a_mag, b_mag, simple_res, res_n, quo, rem, div_final;
  logic [4:0]      op_q;
  logic            neg_q, rneg_q, zero_q;
  logic [XLEN-1:0] result_q;

  assign oReady  = (state == ST_IDLE) || (state == ST_DONE);
  assign oBusy   = (state == ST_MUL) || (state == ST_DIV);
  assign oDone   = (state == ST_DONE);
  assign oResult = result_q;
  assign oZero   = zero_q;
  assign accept  = iStart && oReady && !iKill;

  assign a_neg    = (iControlSignal inside {OPMULH, OPMULHSU, OPDIV, OPREM}) && iA[XLEN-1];
  assign b_neg    = (iControlSignal inside {OPMULH, OPDIV, OPREM}) && iB[XLEN-1];
  assign a_mag    = a_neg ? -iA : iA;
  assign b_mag    = b_neg ? -iB : iB;
  assign b_zero   = (iB == '0);
  assign div_ovf  = (iControlSignal inside {OPDIV, OPREM}) && (iA == MOST_NEG) && (iB == '1);
  assign is_div   = iControlSignal inside {OPDIV, OPDIVU, OPREM, OPREMU};
  assign div_iter = is_div && !b_zero && !div_ovf;
`ifdef ALU_MUL_1CYCLE_EN
  assign iter_mul = 1'b0;
`else
  assign iter_mul = is_muldiv(iControlSignal) && !is_div;
`endif
  assign div_start = accept && (iter_mul || div_iter);

`ifdef ALU_MUL_1CYCLE_EN
  logic [2*XLEN-1:0] prod_full;
  assign prod_full = {{XLEN{a_neg}}, iA} * {{XLEN{b_neg}}, iB};
`endif

  // Single-cycle results; for DIV* only the divide-by-zero/overflow values are ever kept
  always_comb begin
    simple_res = '0;
    case (iControlSignal)
      OPAND:  simple_res = iA & iB;
      OPOR:   simple_res = iA | iB;
      OPXOR:  simple_res = iA ^ iB;
      OPADD:  simple_res = iA + iB;
      OPSUB:  simple_res = iA - iB;
      OPSLT:  simple_res = XLEN'($signed(iA) < $signed(iB));
      OPSLTU: simple_res = XLEN'(iA < iB);
      OPGE:   simple_res = XLEN'($signed(iA) >= $signed(iB));
      OPGEU:  simple_res = XLEN'(iA >= iB);
      OPSLL:  simple_res = iA << iB[SHW-1:0];
      OPSRL:  simple_res = iA >> iB[SHW-1:0];
      OPSRA:  simple_res = $unsigned($signed(iA) >>> iB[SHW-1:0]);
      OPLUI:  simple_res = (iA >> 12) << 12;
      OPBEQ:  simple_res = XLEN'(iA == iB);
      OPBNE:  simple_res = XLEN'(iA != iB);
`ifdef ALU_MUL_1CYCLE_EN
      OPMUL:  simple_res = prod_full[XLEN-1:0];
      OPMULH, OPMULHSU, OPMULHU: simple_res = prod_full[2*XLEN-1:XLEN];
`endif
      OPDIV, OPDIVU: simple_res = b_zero ? '1 : iA;
      OPREM, OPREMU: simple_res = b_zero ? iA : '0;
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        if (accept) begin
          if (iter_mul)      state_n = ST_MUL;
          else if (div_iter) state_n = ST_DIV;
          else               state_n = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (iKill)         state_n = ST_IDLE;
        else if (div_last) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      op_q   <= iControlSignal;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end
  end

  alu_divisor_iterativo #(.XLEN(XLEN), .CNTW(CNTW)) u_div (
    .clk       (iCLK),
    .rst_n     (iRSTn),
    .start     (div_start),
    .kill      (iKill),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .last      (div_last),
    .quotient  (quo),
    .remainder (rem)
  );

  assign div_final = (op_q inside {OPDIV, OPDIVU}) ? (neg_q ? -quo : quo)
                                                   : (rneg_q ? -rem : rem);

`ifndef ALU_MUL_1CYCLE_EN
  logic [XLEN-1:0]   mul_a_q, mul_hi_q, mul_lo_q, mul_hi_n, mul_lo_n, mul_final;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod;

  // Shift-add: multiplier bits leave mul_lo from the bottom as product bits enter from the top
  assign mul_sum   = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mul_a_q} : '0);
  assign mul_hi_n  = mul_sum[XLEN:1];
  assign mul_lo_n  = {mul_sum[0], mul_lo_q[XLEN-1:1]};
  assign mul_prod  = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
  assign mul_final = (op_q == OPMUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      mul_a_q  <= '0;
      mul_hi_q <= '0;
      mul_lo_q <= '0;
    end else if (div_start) begin
      mul_a_q  <= a_mag;
      mul_hi_q <= '0;
      mul_lo_q <= b_mag;
    end else if (state == ST_MUL) begin
      mul_hi_q <= mul_hi_n;
      mul_lo_q <= mul_lo_n;
    end
  end
`endif

  always_comb begin
    load_res = 1'b0;
    res_n    = simple_res;
    if (accept && (state_n == ST_DONE)) begin
      load_res = 1'b1;
    end else if ((state == ST_DIV) && div_last && !iKill) begin
      load_res = 1'b1;
      res_n    = div_final;
    end
`ifndef ALU_MUL_1CYCLE_EN
    else if ((state == ST_MUL) && div_last && !iKill) begin
      load_res = 1'b1;
      res_n    = mul_final;
    end
`endif
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (load_res) begin
      result_q <= res_n;
      zero_q   <= (res_n == XLEN'(ZERO));
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (XLEN=32); expected latencies follow ALU_MUL_1CYCLE_EN.
module tb_alu_multiciclo;
  import alu_multiciclo_pkg::*;

  localparam int XLEN  = 32;
  localparam int LIMIT = 100;
`ifdef ALU_MUL_1CYCLE_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [7:0]  lat;
  } exp_t;

  logic            iCLK = 1'b0;
  logic            iRSTn, iStart, iKill;
  logic [4:0]      iControlSignal;
  logic [XLEN-1:0] iA, iB;
  logic            oReady, oBusy, oDone, oZero;
  logic [XLEN-1:0] oResult;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res;

  alu_multiciclo #(.XLEN(XLEN)) dut (
    .iCLK           (iCLK),
    .iRSTn          (iRSTn),
    .iStart         (iStart),
    .iKill          (iKill),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .oReady         (oReady),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oResult        (oResult),
    .oZero          (oZero)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Issue one op from IDLE/DONE, then wait for oDone and score it against the queued entry
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res, input int lat);
    int   n;
    logic busy_ok;
    exp_t e;
    sb.push_back('{res: res, zero: (res == 32'h0), lat: 8'(lat)});
    iControlSignal = op;
    iA             = a;
    iB             = b;
    iStart         = 1'b1;
    tick();
    iStart  = 1'b0;
    n       = 1;
    busy_ok = 1'b1;
    while (!oDone && n < LIMIT) begin
      if (oReady || !oBusy) busy_ok = 1'b0;
      tick();
      n++;
    end
    e = sb.pop_front();
    checkOutput({tag, "/latency"}, n, 32'(e.lat));
    checkOutput({tag, "/result"}, oResult, e.res);
    checkOutput({tag, "/zero"}, 32'(oZero), 32'(e.zero));
    if (lat > 1) checkOutput({tag, "/busy_handshake"}, 32'(busy_ok), 32'd1);
    last_res = res;
  endtask

  initial begin
    int   c, k;
    logic done_seen;
    exp_t e;
    string tags[3] = '{"b2b_add", "b2b_mul", "b2b_and"};

    iRSTn = 1'b0; iStart = 1'b0; iKill = 1'b0;
    iControlSignal = OPAND; iA = '0; iB = '0;
    tick(); tick();
    checkOutput("reset/result", oResult, 32'h0);
    checkOutput("reset/zero", 32'(oZero), 32'd1);
    checkOutput("reset/flags", {29'd0, oReady, oBusy, oDone}, 32'b100);
    iRSTn = 1'b1;
    tick();

    applyStimulus("add",   OPADD,  32'd7,         32'hFFFF_FFFD, 32'd4,         1);
    applyStimulus("sub",   OPSUB,  32'd5,         32'd5,         32'd0,         1);
    applyStimulus("and",   OPAND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1);
    applyStimulus("xor",   OPXOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    applyStimulus("slt",   OPSLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    applyStimulus("sltu",  OPSLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    applyStimulus("sra",   OPSRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    applyStimulus("srl",   OPSRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    applyStimulus("sll",   OPSLL,  32'd1,         32'd33,        32'd2,         1);
    applyStimulus("lui",   OPLUI,  32'h1234_5678, 32'd0,         32'h1234_5000, 1);
    applyStimulus("ge",    OPGE,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1);
    applyStimulus("beq",   OPBEQ,  32'd3,         32'd3,         32'd1,         1);
    applyStimulus("bne",   OPBNE,  32'd3,         32'd3,         32'd0,         1);

    applyStimulus("mul",    OPMUL,    32'h0001_0000, 32'h0001_0000, 32'h0,         MUL_LAT);
    applyStimulus("mulhu",  OPMULHU,  32'h0001_0000, 32'h0001_0000, 32'h1,         MUL_LAT);
    applyStimulus("mulh",   OPMULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         MUL_LAT);
    applyStimulus("mulhsu", OPMULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
    applyStimulus("mul_neg", OPMUL,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MUL_LAT);

    applyStimulus("div",     OPDIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    applyStimulus("rem",     OPREM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    applyStimulus("divu",    OPDIVU, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    applyStimulus("remu",    OPREMU, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    applyStimulus("div_neg", OPDIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    applyStimulus("rem_pos", OPREM,  32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);

    applyStimulus("div_by0",  OPDIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    applyStimulus("divu_by0", OPDIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    applyStimulus("remu_by0", OPREMU, 32'd5,         32'd0,         32'd5,         1);
    applyStimulus("div_ovf",  OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem_ovf",  OPREM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    applyStimulus("sll_pre",  OPSLL,  32'd1,         32'd4,         32'h10,        1);

    // Abort a DIVU ten cycles in: no oDone may follow and oResult must hold
    iControlSignal = OPDIVU; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (9) tick();
    checkOutput("kill/busy_before", 32'(oBusy), 32'd1);
    iKill = 1'b1;
    tick();
    iKill = 1'b0;
    checkOutput("kill/flags_after", {29'd0, oReady, oBusy, oDone}, 32'b100);
    done_seen = 1'b0;
    repeat (40) begin
      if (oDone) done_seen = 1'b1;
      tick();
    end
    checkOutput("kill/no_done", 32'(done_seen), 32'd0);
    checkOutput("kill/result_held", oResult, last_res);

    // Start while killed in IDLE is dropped
    iControlSignal = OPADD; iA = 32'd1; iB = 32'd1; iStart = 1'b1; iKill = 1'b1;
    tick();
    iStart = 1'b0; iKill = 1'b0;
    checkOutput("kill_start/no_done", 32'(oDone), 32'd0);
    tick();
    checkOutput("kill_start/result_held", oResult, last_res);

    // Back-to-back with iStart held: next op is presented as each oDone is seen
    sb.push_back('{res: 32'd3,       zero: 1'b0, lat: 8'(1)});
    sb.push_back('{res: 32'h12_3400, zero: 1'b0, lat: 8'(1 + MUL_LAT)});
    sb.push_back('{res: 32'hF000,    zero: 1'b0, lat: 8'(2 + MUL_LAT)});
    iControlSignal = OPADD; iA = 32'd1; iB = 32'd2; iStart = 1'b1;
    c = 0;
    k = 0;
    while (sb.size() > 0 && c < LIMIT) begin
      tick();
      c++;
      if (oDone) begin
        e = sb.pop_front();
        checkOutput({tags[k], "/cycle"}, c, 32'(e.lat));
        checkOutput({tags[k], "/result"}, oResult, e.res);
        k++;
        case (k)
          1: begin iControlSignal = OPMUL; iA = 32'h1234; iB = 32'h100; end
          2: begin iControlSignal = OPAND; iA = 32'hF0F0; iB = 32'hFF00; end
          default: iStart = 1'b0;
        endcase
      end
    end
    iStart = 1'b0;
    checkOutput("b2b/drained", sb.size(), 32'd0);
    tick();

    // Asynchronous reset in the middle of a multiply
    iControlSignal = OPMUL; iA = 32'd3; iB = 32'd5; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (5) tick();
    iRSTn = 1'b0;
    #1;
    checkOutput("rst_mid/result", oResult, 32'h0);
    checkOutput("rst_mid/zero", 32'(oZero), 32'd1);
    checkOutput("rst_mid/flags", {29'd0, oReady, oBusy, oDone}, 32'b100);
    tick();
    iRSTn = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      if (oDone) done_seen = 1'b1;
      tick();
    end
    checkOutput("rst_mid/no_done", 32'(done_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
